alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Decode/issue stage that sits directly upstream of the RV32I ALU: accepts fetched instructions plus register-file read data, decodes them and drives registered ALU operands, ALU control code and writeback info.
- Valid/ready handshake on both sides; a 2-entry skid buffer gives full throughput with a registered in_ready.
- Sole producer of the 4-bit ALU control code, so it owns that encoding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- ALUC_W, 4, ALU control code width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- in_rs1_data  in  32  rs1 read data
- in_rs2_data  in  32  rs2 read data
- out_valid  out  1  issue entry valid
- out_ready  in  1  ALU/execute stage accepts
- out_a  out  32  ALU operand A1
- out_b  out  32  ALU operand A2
- out_alu_cont  out  4  ALU control code
- out_rd  out  5  destination register
- out_wr_en  out  1  writeback enable; 0 when rd==0, STORE or illegal
- out_is_mem  out  1  result is a LOAD/STORE address
- out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (async, active-high): out_valid=0, in_ready=1, and all data outputs are 0. Any held entry is discarded immediately when rst rises.
- ALU codes:
  - ADD 0000, SUB 1000, XOR 0100, OR 0110, AND 0111
  - SLL 0001, SRL 0101, SRA 1101, SLT 0010, SLTU 0011
  - For OP the code is {funct7[5], funct3}.
- OP (0110011):
  - a=rs1, b=rs2; shifts use b={27'b0, rs2[4:0]}.
  - funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
- OP-IMM (0010011):
  - a=rs1, b=sign-extended imm[11:0].
  - Code {0, funct3}, except SRAI = 1101.
  - SLLI/SRLI/SRAI: b={27'b0, shamt}. SLLI needs funct7=0000000; SRLI/SRAI need 0000000/0100000; otherwise illegal.
- LUI: a=0, b={imm[31:12], 12'b0}, ADD.
- AUIPC: a=pc, b=U-immediate, ADD.
- LOAD: a=rs1, b=sign-extended I-immediate, ADD, out_is_mem=1.
- STORE: a=rs1, b=sign-extended S-immediate, ADD, out_is_mem=1, wr_en=0.
- Any other opcode is illegal: a=b=0, code ADD, wr_en=0.
- Latency: the decoded entry appears on out_* the cycle after in_valid&&in_ready, when the buffer was empty.
- Skid buffer states:
  - EMPTY: in_ready=1, out_valid=0.
    - in accepted -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - in and out together -> ONE (output register reloads).
    - in only -> TWO (the new entry goes to the skid register).
    - out only -> EMPTY.
  - TWO: out_valid=1, in_ready=0.
    - out accepted -> ONE (the skid entry moves to the output).
- Output stability: out_* is stable while out_valid && !out_ready.
- Ordering: strict FIFO order; no drops, no duplicates.
- Input side: in_* is ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_TRAP_EN
- Defined: an illegal instruction is issued with out_illegal=1 and wr_en=0. It also sets an internal sticky flag; while that flag is set, in_ready is forced to 0 (halts intake) until rst.
- Undefined: out_illegal is tied to 0. Illegal instructions issue as a NOP (a=b=0, ADD, wr_en=0, rd=0) and intake continues.

Decomposition:
- Shared package alu_pkg holds:
  - ALU code constants (ALU_ADD ... ALU_SLTU)
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE)
  - the issue-entry struct typedef {a, b, alu_cont, rd, wr_en, is_mem, illegal}
- One combinational sub-module, alu_issue_decode: instr+pc+rs data -> entry struct.
- The top holds the skid-buffer FSM and registers.

Test Plan:
- Reset, then "add x3,x1,x2" with rs1=5, rs2=7 -> next cycle out_valid=1, a=5, b=7, cont=0000, rd=3, wr_en=1.
- "srai x4,x1,3" (0x4030D213) with rs1=0x80000000 -> b=3, cont=1101.
- "sub x5,x1,x2" (0x402082B3) -> cont=1000. funct7=0100000 with funct3=110 -> illegal.
- Back-pressure: out_ready=0 while sending 3 instructions -> 2 accepted, in_ready=0 after the second, out_* stable. Then release -> all delivered in order with no loss.
- Streaming: out_ready=1, in_valid=1 for 10 cycles -> 10 issues in 10 cycles with in_ready held at 1. "lui x1,0x12345" -> a=0, b=0x12345000. "sw" -> wr_en=0, is_mem=1.
- Assert rst mid-stream while in TWO -> out_valid=0 and in_ready=1 immediately. Opcode 0x7F: with the macro, out_illegal=1 and in_ready stays 0 afterwards; without it, a NOP with wr_en=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the decode/issue stage feeding the RV32I ALU.
//   - ALU control code constants (this stage owns the encoding)
//   - RV32I opcode constants for the classes the stage decodes
//   - issue_entry_t: one decoded entry {a, b, alu_cont, rd, wr_en, is_mem, illegal}
//   - skid_state_t: occupancy of the 2-entry issue skid buffer
//   - sext12(): sign-extend a 12-bit immediate to XLEN
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int ALUC_W = 4;

  localparam logic [ALUC_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALUC_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALUC_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALUC_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_SLTU = 4'b0011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [ALUC_W-1:0] alu_cont;
    logic [4:0]        rd;
    logic              wr_en;
    logic              is_mem;
    logic              illegal;
  } issue_entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_t;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational RV32I decode for the ALU issue stage.
// Ports:
//   instr     in   instruction word
//   pc        in   instruction address (AUIPC operand A)
//   rs1_data  in   rs1 read data
//   rs2_data  in   rs2 read data
//   entry     out  decoded issue entry; an illegal instruction yields an
//                  all-zero entry (ADD, rd=0, wr_en=0) with illegal=1
import alu_pkg::*;

module alu_issue_decode (
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs1_data,
  input  logic [31:0]  rs2_data,
  output issue_entry_t entry
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [31:0] shamt_imm;
  logic       illegal;
  logic       unused_rs1_idx;

  assign opc       = instr[6:0];
  assign rd        = instr[11:7];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign shamt_imm = {27'b0, instr[24:20]};
  // rs1 index is resolved by the register file upstream; only its data arrives here
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    entry   = '0;
    illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        entry.a        = rs1_data;
        entry.b        = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, rs2_data[4:0]} : rs2_data;
        entry.alu_cont = {f7[5], f3};
        entry.rd       = rd;
        entry.wr_en    = (rd != 5'd0);
        if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        entry.a        = rs1_data;
        entry.b        = sext12(instr[31:20]);
        entry.alu_cont = {1'b0, f3};
        entry.rd       = rd;
        entry.wr_en    = (rd != 5'd0);
        if (f3 == 3'b001) begin
          entry.b = shamt_imm;
          if (f7 != 7'b0000000) illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          entry.b = shamt_imm;
          if (f7 == 7'b0100000)      entry.alu_cont = ALU_SRA;
          else if (f7 != 7'b0000000) illegal = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        entry.a     = (opc == OPC_AUIPC) ? pc : 32'd0;
        entry.b     = {instr[31:12], 12'b0};
        entry.rd    = rd;
        entry.wr_en = (rd != 5'd0);
      end
      OPC_LOAD: begin
        entry.a      = rs1_data;
        entry.b      = sext12(instr[31:20]);
        entry.rd     = rd;
        entry.wr_en  = (rd != 5'd0);
        entry.is_mem = 1'b1;
      end
      OPC_STORE: begin
        // instr[11:7] is immediate here, so no destination is reported
        entry.a      = rs1_data;
        entry.b      = sext12({instr[31:25], instr[11:7]});
        entry.is_mem = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      entry         = '0;
      entry.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage in front of the RV32I ALU, with a 2-entry
// skid buffer (output register + skid register) so in_ready can be a flop
// while still sustaining one issue per cycle.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready                upstream handshake (in_ready registered)
//   in_instr, in_pc, in_rs1_data,
//   in_rs2_data                      instruction and register-file read data
//   out_valid/out_ready              downstream handshake
//   out_a, out_b, out_alu_cont       registered ALU operands and control code
//   out_rd, out_wr_en, out_is_mem    writeback / memory-address info
//   out_illegal                      undecodable instruction flag
// Build option ALU_ISSUE_ILLEGAL_TRAP_EN: when defined, illegal instructions
// issue with out_illegal=1 and halt intake (in_ready=0) until reset; when
// undefined, they issue as a NOP and out_illegal stays 0.
//
// state   | meaning
// EMPTY   | nothing held; out_valid=0
// ONE     | output register holds an entry
// TWO     | output and skid registers full; in_ready=0
import alu_pkg::*;

module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_alu_cont,
  output logic [4:0]  out_rd,
  output logic        out_wr_en,
  output logic        out_is_mem,
  output logic        out_illegal
);

  skid_state_t  state, next_state;
  issue_entry_t dec, ld, out_q, skid_q;
  logic         acc_in, acc_out;
  logic         ld_out_dec, ld_out_skid, ld_skid;
  logic         in_ready_q, in_ready_d;
  logic         halt_q, halt_d;

  alu_issue_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .entry    (dec)
  );

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign ld     = dec;
  // latched on acceptance so in_ready drops the cycle after the illegal one
  assign halt_d = halt_q | (acc_in & dec.illegal);
`else
  always_comb begin
    ld         = dec;
    ld.illegal = 1'b0;
  end
  assign halt_d = 1'b0;
`endif

  assign acc_in  = in_valid & in_ready_q;
  assign acc_out = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    ld_out_dec  = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (acc_in) begin
          ld_out_dec = 1'b1;
          next_state = S_ONE;
        end
      end
      S_ONE: begin
        if (acc_in && acc_out) begin
          ld_out_dec = 1'b1;
        end else if (acc_in) begin
          ld_skid    = 1'b1;
          next_state = S_TWO;
        end else if (acc_out) begin
          next_state = S_EMPTY;
        end
      end
      S_TWO: begin
        if (acc_out) begin
          ld_out_skid = 1'b1;
          next_state  = S_ONE;
        end
      end
      default: next_state = S_EMPTY;
    endcase
  end

  assign in_ready_d = (next_state != S_TWO) & ~halt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      halt_q     <= 1'b0;
    end else begin
      if (ld_out_dec)       out_q <= ld;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= ld;
      in_ready_q <= in_ready_d;
      halt_q     <= halt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state != S_EMPTY);
  assign out_a        = out_q.a;
  assign out_b        = out_q.b;
  assign out_alu_cont = out_q.alu_cont;
  assign out_rd       = out_q.rd;
  assign out_wr_en    = out_q.wr_en;
  assign out_is_mem   = out_q.is_mem;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: random and directed instructions, scoreboard of
// expected issue entries computed from the RV32I decode rules.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_alu_cont;
  logic [4:0]  out_rd;
  logic        out_wr_en, out_is_mem, out_illegal;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  alu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_cont(out_alu_cont),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_is_mem(out_is_mem),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  rd;
    logic        wr;
    logic        mem;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  // Reference decode written from the instruction-set rules
  function automatic exp_t model(input logic [31:0] instr, pc, rs1, rs2);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] iimm, simm, uimm, shamt;
    bit bad;
    opc = instr[6:0]; rd = instr[11:7]; f3 = instr[14:12]; f7 = instr[31:25];
    iimm  = $signed(instr) >>> 20;
    simm  = $signed(instr) >>> 25;
    simm  = (simm << 5) | {27'b0, instr[11:7]};
    uimm  = instr & 32'hFFFF_F000;
    shamt = (instr >> 20) & 32'h1F;
    e = '{a: 0, b: 0, c: 0, rd: 0, wr: 0, mem: 0, ill: 0};
    bad = 1'b0;
    case (opc)
      7'h33: begin
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        e.a = rs1;
        e.b = (f3 == 3'd1 || f3 == 3'd5) ? (rs2 & 32'h1F) : rs2;
        e.c = {f7[5], f3};
        e.rd = rd; e.wr = (rd != 0);
      end
      7'h13: begin
        e.a = rs1; e.b = iimm; e.c = {1'b0, f3}; e.rd = rd; e.wr = (rd != 0);
        if (f3 == 3'd1) begin e.b = shamt; bad = (f7 != 7'h00); end
        if (f3 == 3'd5) begin
          e.b = shamt;
          bad = !(f7 == 7'h00 || f7 == 7'h20);
          if (f7 == 7'h20) e.c = 4'hD;
        end
      end
      7'h37: begin e.b = uimm; e.rd = rd; e.wr = (rd != 0); end
      7'h17: begin e.a = pc; e.b = uimm; e.rd = rd; e.wr = (rd != 0); end
      7'h03: begin e.a = rs1; e.b = iimm; e.rd = rd; e.wr = (rd != 0); e.mem = 1; end
      7'h23: begin e.a = rs1; e.b = simm; e.mem = 1; end
      default: bad = 1'b1;
    endcase
    if (bad) e = '{a: 0, b: 0, c: 0, rd: 0, wr: 0, mem: 0, ill: TRAP};
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int cls;
    r   = $urandom;
    f3  = r[14:12];
    f7  = r[31:25];
    cls = $urandom_range(0, 5);
    case (cls)
      0: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
        return {f7, r[24:15], f3, r[11:7], 7'h33};
      end
      1: begin
        if (f3 == 3'd1) f7 = 7'h00;
        if (f3 == 3'd5) f7 = r[1] ? 7'h20 : 7'h00;
        return {f7, r[24:15], f3, r[11:7], 7'h13};
      end
      2: return {r[31:7], 7'h37};
      3: return {r[31:7], 7'h17};
      4: return {r[31:7], 7'h03};
      default: return {r[31:7], 7'h23};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor and hold-stability check
  logic        hold = 1'b0;
  logic [75:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold && out_valid) begin
        checks++;
        if ({out_a, out_b, out_alu_cont, out_rd, out_wr_en, out_is_mem, out_illegal} !== held) begin
          errors++;
          $display("FAIL stable: outputs changed while stalled, got a=%h b=%h expected a=%h b=%h",
                   out_a, out_b, held[75:44], held[43:12]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_issue: got a=%h b=%h with nothing expected", out_a, out_b);
        end else begin
          e = exp_q.pop_front();
          if (out_a !== e.a || out_b !== e.b || out_alu_cont !== e.c || out_rd !== e.rd ||
              out_wr_en !== e.wr || out_is_mem !== e.mem || out_illegal !== e.ill) begin
            errors++;
            $display("FAIL issue%0d: got a=%h b=%h c=%h rd=%0d wr=%b mem=%b ill=%b expected a=%h b=%h c=%h rd=%0d wr=%b mem=%b ill=%b",
                     pops, out_a, out_b, out_alu_cont, out_rd, out_wr_en, out_is_mem, out_illegal,
                     e.a, e.b, e.c, e.rd, e.wr, e.mem, e.ill);
          end
        end
        pops++;
      end
      hold = out_valid && !out_ready;
      held = {out_a, out_b, out_alu_cont, out_rd, out_wr_en, out_is_mem, out_illegal};
    end
  end

  // Holds the inputs until accepted; returns 1 ns after the accepting edge
  task automatic send(input logic [31:0] instr, pc, rs1, rs2);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(model(instr, pc, rs1, rs2));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; #1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int p0, c0;
    logic [31:0] held_a;
    bit done;

    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_misc", {20'd0, out_alu_cont, out_rd, out_wr_en, out_is_mem, out_illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // directed decode
    out_ready = 1'b1;
    send(32'h002081B3, 32'h100, 32'd5, 32'd7); in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_cont", 32'(out_alu_cont), 32'h0);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_wr", 32'(out_wr_en), 32'd1);
    send(32'h4030D213, 32'h104, 32'h8000_0000, 32'd0); in_valid = 1'b0;
    chk("srai_b", out_b, 32'd3);
    chk("srai_cont", 32'(out_alu_cont), 32'hD);
    send(32'h402082B3, 32'h108, 32'd9, 32'd4); in_valid = 1'b0;
    chk("sub_cont", 32'(out_alu_cont), 32'h8);
    send(32'h123450B7, 32'h10C, 32'hDEAD_BEEF, 32'd1); in_valid = 1'b0;
    chk("lui_a", out_a, 32'd0);
    chk("lui_b", out_b, 32'h1234_5000);
    send(32'h0020A423, 32'h110, 32'h1000, 32'h55); in_valid = 1'b0;
    chk("sw_wr", 32'(out_wr_en), 32'd0);
    chk("sw_mem", 32'(out_is_mem), 32'd1);
    chk("sw_b", out_b, 32'd8);
    @(posedge clk); #1;

    // back-pressure: two accepted, third waits, all delivered in order
    out_ready = 1'b0;
    p0 = pops;
    send(32'h002081B3, 32'h200, 32'h11, 32'h1);
    send(32'h002081B3, 32'h204, 32'h22, 32'h2);
    in_valid = 1'b0;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    held_a = out_a;
    fork
      send(32'h002081B3, 32'h208, 32'h33, 32'h3);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_hold_a", out_a, 32'h11);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(pops - p0), 32'd3);
    chk("bp_first_a", held_a, 32'h11);

    // streaming at full rate
    p0 = pops;
    c0 = cyc;
    for (int i = 0; i < 10; i++) send(rand_instr(), $urandom, $urandom, $urandom);
    chk("stream_cycles", 32'(cyc - c0), 32'd10);
    chk("stream_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_count", 32'(pops - p0), 32'd10);

    // randomized traffic with random back-pressure and gaps
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          send(rand_instr(), $urandom, $urandom, $urandom);
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // reset while in TWO
    out_ready = 1'b0;
    send(32'h002081B3, 32'h300, 32'h44, 32'h4);
    send(32'h002081B3, 32'h304, 32'h55, 32'h5);
    in_valid = 1'b0;
    chk("two_in_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_a", out_a, 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    send(32'h002081B3, 32'h308, 32'd1, 32'd2); in_valid = 1'b0;
    drain();

    // illegal funct7 on OP
    send(32'h4020E2B3, 32'h400, 32'd9, 32'd9); in_valid = 1'b0;
    chk("badf7_illegal", 32'(out_illegal), 32'(TRAP));
    chk("badf7_wr", 32'(out_wr_en), 32'd0);
    chk("badf7_a", out_a, 32'd0);
    drain();
    repeat (2) @(posedge clk); #1;
    chk("badf7_in_ready", 32'(in_ready), 32'(!TRAP));
    if (TRAP) pulse_rst();

    // unknown opcode 0x7F
    send(32'h1234_56FF, 32'h500, 32'd3, 32'd3); in_valid = 1'b0;
    chk("opc7f_illegal", 32'(out_illegal), 32'(TRAP));
    chk("opc7f_wr", 32'(out_wr_en), 32'd0);
    chk("opc7f_rd", 32'(out_rd), 32'd0);
    drain();
    repeat (3) @(posedge clk); #1;
    chk("opc7f_in_ready", 32'(in_ready), 32'(!TRAP));
    if (!TRAP) begin
      send(32'h002081B3, 32'h504, 32'd6, 32'd6); in_valid = 1'b0;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
